// File: rtl/masku_result_shuffler.sv
// masku_result_shuffler: lane-shuffles deshuffled mask-unit result words and queues them
// in a 2-entry FIFO for independent per-lane VRF writes.
module masku_result_shuffler #(
  parameter int NrLanes   = 4,
  parameter int ELEN      = 64,
  parameter int AddrWidth = 32,
  localparam int ELEN_BYTES = ELEN / 8,
  localparam int DW         = NrLanes * ELEN
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  input  logic [DW-1:0]                    res_data_i,
  input  logic [DW-1:0]                    res_be_i,
  input  logic [1:0]                       res_eew_i,
  input  logic [AddrWidth-1:0]             res_addr_i,
  input  logic [2:0]                       res_id_i,
  input  logic                             res_last_i,
  output logic [NrLanes-1:0]               lane_req_o,
  output logic [AddrWidth-1:0]             lane_addr_o,
  output logic [2:0]                       lane_id_o,
  output logic [DW-1:0]                    lane_wdata_o,
  output logic [NrLanes*ELEN_BYTES-1:0]    lane_be_o,
  input  logic [NrLanes-1:0]               lane_gnt_i,
  output logic                             done_o,
  output logic [15:0]                      words_o
);
  localparam int DWB = DW / 8;
  localparam int BW  = $clog2(DWB);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state, state_nxt;
  logic [7:0] src_d [DWB];
  logic [DWB-1:0] src_s, sh_s;
  logic [DW-1:0] sh_d;
  logic [NrLanes-1:0] sh_p, pend_nxt;
  logic [DW-1:0] mem_d [2];
  logic [DWB-1:0] mem_s [2];
  logic [AddrWidth-1:0] mem_a [2];
  logic [2:0] mem_id [2];
  logic [NrLanes-1:0] mem_p [2];
  logic [1:0] mem_last, cnt;
  logic rd, wr, head_valid, push, pop;
  // Inverse of the element-to-lane mapping: which source byte lands on destination byte d.
  function automatic logic [BW-1:0] src_byte(input int d, input logic [1:0] eew);
    int ew, lane, slot, k;
    ew = 1 << eew;
    lane = d / ELEN_BYTES;
    slot = (d % ELEN_BYTES) / ew;
    k = d % ew;
    return BW'((slot * NrLanes + lane) * ew + k);
  endfunction
  for (genvar i = 0; i < DWB; i++) begin : g_byte
    assign src_d[i] = res_data_i[8*i +: 8];
    assign src_s[i] = |res_be_i[8*i +: 8];
    assign sh_d[8*i +: 8] = src_d[src_byte(i, res_eew_i)];
    assign sh_s[i] = src_s[src_byte(i, res_eew_i)];
  end
  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
    assign sh_p[l] = |sh_s[l*ELEN_BYTES +: ELEN_BYTES];
  end
  assign head_valid   = state == BUSY;
  assign res_ready_o  = cnt != 2'd2;
  assign push         = res_valid_i && res_ready_o;
  assign lane_req_o   = head_valid ? mem_p[rd] : '0;
  assign pend_nxt     = mem_p[rd] & ~lane_gnt_i;
  assign pop          = head_valid && pend_nxt == '0;
  assign lane_addr_o  = mem_a[rd];
  assign lane_id_o    = mem_id[rd];
  assign lane_wdata_o = mem_d[rd];
  assign lane_be_o    = mem_s[rd];
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && push) ? BUSY :
                (pop && !push && cnt == 2'd1) ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      mem_p   <= '{default: '0};
      done_o  <= 1'b0;
      words_o <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt + 2'(push) - 2'(pop);
      rd     <= rd ^ pop;
      wr     <= wr ^ push;
      done_o <= pop && mem_last[rd];
      if (pop) words_o <= mem_last[rd] ? '0 : words_o + 16'd1;
      if (head_valid) mem_p[rd] <= pend_nxt;
      if (push) begin
        mem_d[wr]    <= sh_d;
        mem_s[wr]    <= sh_s;
        mem_a[wr]    <= res_addr_i;
        mem_id[wr]   <= res_id_i;
        mem_last[wr] <= res_last_i;
        mem_p[wr]    <= sh_p;
      end
    end
  end
endmodule
